// File: rtl/palette_loader_pkg.sv
// Shared types for the palette loader slice.
//   rgb24_t      packed {r,g,b} colour entry, r in the top byte
//   SWZ_*        lookup output orderings
//   pal_state_t  loader FSM states
//   swizzle_rgb  reorders an {r,g,b} entry for the lookup output
package palette_loader_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  localparam int SWZ_RGB = 0;
  localparam int SWZ_BRG = 1;

  typedef enum logic [1:0] {
    PAL_IDLE    = 2'd0,
    PAL_COLLECT = 2'd1,
    PAL_FULL    = 2'd2
  } pal_state_t;

  function automatic logic [23:0] swizzle_rgb(input rgb24_t c, input int swz);
    if (swz == SWZ_BRG) return {c.b, c.r, c.g};
    return {c.r, c.g, c.b};
  endfunction

endpackage

// File: rtl/palette_loader_if.sv
// Bus bundle between the download/lookup side and the palette loader.
//   ioctl_download/ioctl_wr/ioctl_dout/pal_load  byte stream from the ROM download
//   fb_pal_addr/fb_pal_dout/fb_pal_wr            framebuffer palette write port
//   lut_en/lut_addr -> lut_rgb/lut_valid         pipelined index->RGB lookup
//   entries_loaded/load_done/overflow            load status
// All strobes are single-cycle qualifiers sampled on the rising clock edge:
// a byte is consumed in any cycle where ioctl_wr is high, a lookup is issued
// in any cycle where lut_en is high, and fb_pal_wr / lut_valid mark the one
// cycle their data is meaningful. There is no back-pressure on any path.
interface palette_loader_if #(
  parameter int IDX_W = 8
);
  logic             ioctl_download;
  logic             ioctl_wr;
  logic [7:0]       ioctl_dout;
  logic             pal_load;
  logic [IDX_W-1:0] fb_pal_addr;
  logic [23:0]      fb_pal_dout;
  logic             fb_pal_wr;
  logic             lut_en;
  logic [IDX_W-1:0] lut_addr;
  logic [23:0]      lut_rgb;
  logic             lut_valid;
  logic [IDX_W:0]   entries_loaded;
  logic             load_done;
  logic             overflow;

  modport master (
    output ioctl_download, ioctl_wr, ioctl_dout, pal_load, lut_en, lut_addr,
    input  fb_pal_addr, fb_pal_dout, fb_pal_wr, lut_rgb, lut_valid,
           entries_loaded, load_done, overflow
  );

  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_dout, pal_load, lut_en, lut_addr,
    output fb_pal_addr, fb_pal_dout, fb_pal_wr, lut_rgb, lut_valid,
           entries_loaded, load_done, overflow
  );
endinterface

// File: rtl/palette_loader_ram.sv
// Simple dual-port palette store, DEPTH x 24.
//   clk_sys  clock
//   we/waddr/wdata  write port
//   raddr -> rdata  registered read, one cycle latency
// A read and a write to the same address in one cycle return the old data.
module palette_ram
  import palette_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk_sys,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  rgb24_t           wdata,
  input  logic [IDX_W-1:0] raddr,
  output rgb24_t           rdata
);

  rgb24_t mem [DEPTH];

  // Contents are never reset so the palette survives a system reset.
  always_ff @(posedge clk_sys) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/palette_loader.sv
// Palette loader and lookup.
// Collects BPE-byte colour entries from the ioctl stream while the palette
// window is active, commits each entry to the internal palette RAM and the
// framebuffer palette port in the same cycle, and serves a 2-cycle lookup.
//   clk_sys    clock
//   reset      synchronous, active-high
//   bus        palette_loader_if slave side (stream in, FB port, lookup, status)
//   state_dbg  current loader FSM state
module palette_loader
  import palette_loader_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int IDX_W   = 8,
  parameter int BPE     = 3,
  parameter int SWIZZLE = 0
) (
  input  logic               clk_sys,
  input  logic               reset,
  palette_loader_if.slave    bus,
  output pal_state_t         state_dbg
);

  localparam logic [IDX_W:0] DEPTH_C   = (IDX_W+1)'(DEPTH);
  localparam logic [1:0]     LAST_SLOT = 2'(BPE - 1);

  pal_state_t       state_q, state_d;
  logic             dl_q;
  logic [1:0]       byte_cnt_q;
  logic [7:0]       r_q, g_q, b_q;
  logic [IDX_W:0]   wr_idx_q;
  logic             fb_wr_q;
  logic [IDX_W-1:0] fb_addr_q;
  rgb24_t           fb_data_q;
  logic             overflow_q;
  logic             load_done_q;

  logic             dl_rise, dl_fall, is_full, byte_take, last_byte;
  rgb24_t           entry_w;

  // dl_q is not reset: it follows ioctl_download even during reset, so a
  // download still high when reset is released does not look like a new rise.
  always_ff @(posedge clk_sys) begin
    dl_q <= bus.ioctl_download;
  end

  assign dl_rise   = bus.ioctl_download & ~dl_q;
  assign dl_fall   = ~bus.ioctl_download & dl_q;
  assign is_full   = (wr_idx_q == DEPTH_C);
  assign byte_take = bus.ioctl_download & bus.ioctl_wr & bus.pal_load &
                     (state_q != PAL_IDLE) & ~dl_rise;
  assign last_byte = byte_take & (byte_cnt_q == LAST_SLOT);

  // With BPE=3 the blue byte is the one arriving now; with BPE=4 the
  // arriving byte is the padding byte and blue is already registered.
  assign entry_w = (BPE == 3) ? {r_q, g_q, bus.ioctl_dout} : {r_q, g_q, b_q};

  // ---------------- FSM ----------------
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= PAL_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (dl_rise) begin
      state_d = PAL_COLLECT;
    end else begin
      case (state_q)
        PAL_COLLECT: begin
          if (dl_fall)      state_d = PAL_IDLE;
          else if (is_full) state_d = PAL_FULL;
        end
        PAL_FULL: begin
          if (dl_fall) state_d = PAL_IDLE;
        end
        default: state_d = state_q;
      endcase
    end
  end

  assign state_dbg = state_q;

  // ------------- byte assembly and commit -------------
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      byte_cnt_q  <= '0;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      wr_idx_q    <= '0;
      fb_wr_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
      overflow_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      fb_wr_q <= 1'b0;
      if (dl_rise) begin
        byte_cnt_q  <= '0;
        wr_idx_q    <= '0;
        overflow_q  <= 1'b0;
        load_done_q <= 1'b0;
      end else begin
        if (byte_take) begin
          byte_cnt_q <= last_byte ? 2'd0 : byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0:    r_q <= bus.ioctl_dout;
            2'd1:    g_q <= bus.ioctl_dout;
            2'd2:    b_q <= bus.ioctl_dout;
            default: ;
          endcase
          if (last_byte) begin
            if (is_full) begin
              overflow_q <= 1'b1;
            end else begin
              fb_wr_q   <= 1'b1;
              fb_addr_q <= wr_idx_q[IDX_W-1:0];
              fb_data_q <= entry_w;
              wr_idx_q  <= wr_idx_q + (IDX_W+1)'(1);
            end
          end
        end
        // wr_idx_q already includes a commit being presented this cycle.
        if (dl_fall && state_q != PAL_IDLE) begin
          byte_cnt_q  <= '0;
          load_done_q <= (wr_idx_q != '0);
        end
      end
    end
  end

  assign bus.fb_pal_wr      = fb_wr_q;
  assign bus.fb_pal_addr    = fb_addr_q;
  assign bus.fb_pal_dout    = fb_data_q;
  assign bus.entries_loaded = wr_idx_q;
  assign bus.overflow       = overflow_q;
  assign bus.load_done      = load_done_q;

  // ---------------- lookup pipeline ----------------
  logic [IDX_W-1:0] rd_addr_q;
  logic             en_d1_q, en_d2_q;
  rgb24_t           rd_data;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_addr_q <= '0;
      en_d1_q   <= 1'b0;
      en_d2_q   <= 1'b0;
    end else begin
      en_d1_q <= bus.lut_en;
      en_d2_q <= en_d1_q;
      if (bus.lut_en) rd_addr_q <= bus.lut_addr;
    end
  end

  palette_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk_sys (clk_sys),
    .we      (fb_wr_q),
    .waddr   (fb_addr_q),
    .wdata   (fb_data_q),
    .raddr   (rd_addr_q),
    .rdata   (rd_data)
  );

  // The RAM output is only meaningful on lut_valid; it is muted while a
  // download is rewriting the palette.
  assign bus.lut_valid = en_d2_q;
  assign bus.lut_rgb   = (en_d2_q && !bus.ioctl_download) ?
                         swizzle_rgb(rd_data, SWIZZLE) : 24'h0;

endmodule
